// File: rtl/lvds_rx_deframe_pkg.sv
// FPD-Link 7:1 (RGB666) constants, aligner state type and lane unpack helper,
// shared by the RX deframer and the TX-side panel path.
package lvds_rx_deframe_pkg;

  localparam int LANE_W    = 7;
  localparam int NUM_LANES = 3;
  localparam int COLOR_W   = 6;

  localparam logic [LANE_W-1:0] CLK_PATTERN = 7'b1100011;

  // Bit positions of the non-colour fields inside each lane word (bit 6 is sent first)
  localparam int L0_G0 = 6;
  localparam int L1_B0 = 5;
  localparam int L1_B1 = 6;
  localparam int L2_HS = 4;
  localparam int L2_VS = 5;
  localparam int L2_DE = 6;

  typedef enum logic [2:0] {
    HUNT,
    SLIP,
    SETTLE,
    CHECK,
    LOCKED
  } align_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               hs;
    logic               vs;
    logic               de;
  } pixel_t;

  function automatic pixel_t unpack_lanes(input logic [NUM_LANES*LANE_W-1:0] word);
    logic [LANE_W-1:0] lane0;
    logic [LANE_W-1:0] lane1;
    logic [LANE_W-1:0] lane2;
    pixel_t            pix;
    lane0  = word[LANE_W-1:0];
    lane1  = word[2*LANE_W-1:LANE_W];
    lane2  = word[3*LANE_W-1:2*LANE_W];
    pix.r  = lane0[5:0];
    pix.g  = {lane1[4:0], lane0[L0_G0]};
    pix.b  = {lane2[3:0], lane1[L1_B1], lane1[L1_B0]};
    pix.hs = lane2[L2_HS];
    pix.vs = lane2[L2_VS];
    pix.de = lane2[L2_DE];
    return pix;
  endfunction

endpackage

// File: rtl/lvds_word_aligner.sv
// Word aligner: slips the deserializers until the clock lane shows the
// reference pattern for CHECK_CYCLES in a row, then watches for loss of lock.
module lvds_word_aligner
  import lvds_rx_deframe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CHECK_CYCLES  = 64,
  parameter int LOSS_ERRS     = 4,
  parameter int MAX_SLIPS     = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [LANE_W-1:0] clk_word,
  output logic              bitslip,
  output logic              locked,
  output logic              align_err
);

  localparam int CW = $clog2(CHECK_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(LOSS_ERRS + 1);
  localparam int PW = $clog2(MAX_SLIPS + 1);

  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MISS_LAST   = MW'(LOSS_ERRS - 1);
  localparam logic [PW-1:0] SLIP_MAX    = PW'(MAX_SLIPS);
  localparam logic [PW-1:0] SLIP_ERR_AT = PW'(MAX_SLIPS - 1);

  align_state_t  state, next_state;
  logic [CW-1:0] check_cnt, check_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [MW-1:0] miss_cnt, miss_nxt;
  logic [PW-1:0] slip_cnt, slip_nxt;
  logic          err_nxt;
  logic          match;

  assign match     = (clk_word == CLK_PATTERN);
  assign bitslip   = (state == SLIP);
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= HUNT;
      check_cnt  <= '0;
      settle_cnt <= '0;
      miss_cnt   <= '0;
      slip_cnt   <= '0;
      align_err  <= 1'b0;
    end else begin
      state      <= next_state;
      check_cnt  <= check_nxt;
      settle_cnt <= settle_nxt;
      miss_cnt   <= miss_nxt;
      slip_cnt   <= slip_nxt;
      align_err  <= err_nxt;
    end
  end

  // Every SLIP is followed by SETTLE and HUNT, so bitslip pulses are spaced SETTLE_CYCLES+2 apart
  always_comb begin
    next_state = state;
    check_nxt  = check_cnt;
    settle_nxt = settle_cnt;
    miss_nxt   = miss_cnt;
    slip_nxt   = slip_cnt;
    err_nxt    = align_err;
    unique case (state)
      HUNT: begin
        if (match) begin
          next_state = CHECK;
          check_nxt  = CW'(1);
        end else begin
          next_state = SLIP;
        end
      end
      SLIP: begin
        next_state = SETTLE;
        settle_nxt = '0;
        if (slip_cnt != SLIP_MAX) slip_nxt = slip_cnt + 1'b1;
        if (slip_cnt >= SLIP_ERR_AT) err_nxt = 1'b1;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          next_state = HUNT;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      CHECK: begin
        if (!match) begin
          next_state = SLIP;
          check_nxt  = '0;
        end else if (check_cnt == CHECK_LAST) begin
          next_state = LOCKED;
          check_nxt  = '0;
          miss_nxt   = '0;
          slip_nxt   = '0;
          err_nxt    = 1'b0;
        end else begin
          check_nxt = check_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (match) begin
          miss_nxt = '0;
        end else if (miss_cnt == MISS_LAST) begin
          next_state = HUNT;
          miss_nxt   = '0;
        end else begin
          miss_nxt = miss_cnt + 1'b1;
        end
      end
      default: next_state = HUNT;
    endcase
  end

endmodule

// File: rtl/lvds_rx_deframe.sv
// FPD-Link 7:1 receive deframer: lane alignment, two-stage RGB666 unpack
// pipeline and active-video x/y position tracking.
module lvds_rx_deframe
  import lvds_rx_deframe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CHECK_CYCLES  = 64,
  parameter int LOSS_ERRS     = 4,
  parameter int MAX_SLIPS     = 7,
  parameter int X_W           = 12,
  parameter int Y_W           = 12
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic [LANE_W-1:0]           i_clk_word,
  input  logic [NUM_LANES*LANE_W-1:0] i_data_word,
  output logic                        o_bitslip,
  output logic                        o_locked,
  output logic                        o_align_err,
  output logic                        o_valid,
  output logic [COLOR_W-1:0]          o_r,
  output logic [COLOR_W-1:0]          o_g,
  output logic [COLOR_W-1:0]          o_b,
  output logic                        o_hs,
  output logic                        o_vs,
  output logic                        o_de,
  output logic [X_W-1:0]              o_x,
  output logic [Y_W-1:0]              o_y
);

  logic [NUM_LANES*LANE_W-1:0] data_s1;
  logic                        valid_s1;
  pixel_t                      pix_s1;

  lvds_word_aligner #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CHECK_CYCLES (CHECK_CYCLES),
    .LOSS_ERRS    (LOSS_ERRS),
    .MAX_SLIPS    (MAX_SLIPS)
  ) u_aligner (
    .clk      (i_clk),
    .resetn   (i_resetn),
    .clk_word (i_clk_word),
    .bitslip  (o_bitslip),
    .locked   (o_locked),
    .align_err(o_align_err)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      data_s1  <= '0;
      valid_s1 <= 1'b0;
    end else begin
      data_s1  <= i_data_word;
      valid_s1 <= o_locked;
    end
  end

  always_comb begin
    pix_s1 = '0;
    if (valid_s1) pix_s1 = unpack_lanes(data_s1);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_valid <= 1'b0;
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
      o_hs    <= 1'b0;
      o_vs    <= 1'b0;
      o_de    <= 1'b0;
    end else begin
      o_valid <= valid_s1;
      o_r     <= pix_s1.r;
      o_g     <= pix_s1.g;
      o_b     <= pix_s1.b;
      o_hs    <= pix_s1.hs;
      o_vs    <= pix_s1.vs;
      o_de    <= pix_s1.de;
    end
  end

  // Edges are seen by comparing the presented sample with the one loading behind it,
  // so a new x/y appears together with the pixel it belongs to; the VS clear is last so it wins
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_x <= '0;
      o_y <= '0;
    end else if (!valid_s1) begin
      o_x <= '0;
      o_y <= '0;
    end else begin
      if (o_de && pix_s1.de) begin
        o_x <= o_x + 1'b1;
      end else if (o_de && !pix_s1.de) begin
        o_x <= '0;
        o_y <= o_y + 1'b1;
      end
      if (pix_s1.vs && !o_vs) o_y <= '0;
    end
  end

endmodule

// File: tb/tb_lvds_rx_deframe.sv
// Directed bench for lvds_rx_deframe: models the deserializer phase/bitslip
// response and checks alignment, unpack, loss of lock, x/y tracking and reset.
module tb_lvds_rx_deframe;

  localparam logic [6:0] PAT = 7'b1100011;

  logic        clk = 1'b0;
  logic        resetn;
  logic [6:0]  clk_word;
  logic [20:0] data_word;
  logic        bitslip, locked, align_err, valid;
  logic [5:0]  r, g, b;
  logic        hs, vs, de;
  logic [11:0] x, y;

  int checks = 0;
  int errors = 0;

  // Deserializer model: every lane is rotated by the same phase; a bitslip advances it by one bit
  int          phase = 0;
  int          slips = 0;
  int          cycle = 0;
  int          last_slip_cycle = -100;
  int          min_gap = 1000;
  logic [6:0]  clk_src = PAT;
  logic [20:0] lanes_src = '0;

  logic [20:0] st_word[64];
  logic [5:0]  st_r[64];
  logic        st_de[64];
  int          st_x[64];
  int          st_y[64];
  int          st_len = 0;
  int          lock_cycle;

  always #5 clk = ~clk;

  lvds_rx_deframe dut (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_clk_word (clk_word),
    .i_data_word(data_word),
    .o_bitslip  (bitslip),
    .o_locked   (locked),
    .o_align_err(align_err),
    .o_valid    (valid),
    .o_r        (r),
    .o_g        (g),
    .o_b        (b),
    .o_hs       (hs),
    .o_vs       (vs),
    .o_de       (de),
    .o_x        (x),
    .o_y        (y)
  );

  function automatic logic [6:0] rot7(input logic [6:0] w, input int p);
    logic [13:0] d;
    d = {w, w} << p;
    return d[13:7];
  endfunction

  function automatic logic [20:0] pack_pixel(input logic [5:0] pr, input logic [5:0] pg,
                                             input logic [5:0] pb, input logic phs,
                                             input logic pvs, input logic pde);
    return {pde, pvs, phs, pb[5:2], pb[1:0], pg[5:1], pg[0], pr};
  endfunction

  task automatic apply_stimulus();
    clk_word  = rot7(clk_src, phase);
    data_word = {rot7(lanes_src[20:14], phase), rot7(lanes_src[13:7], phase),
                 rot7(lanes_src[6:0], phase)};
  endtask

  // One cycle: sample at the falling edge, react to bitslip, drive the next words
  task automatic step();
    @(negedge clk);
    cycle++;
    if (bitslip) begin
      slips++;
      if (cycle - last_slip_cycle < min_gap) min_gap = cycle - last_slip_cycle;
      last_slip_cycle = cycle;
      phase = (phase + 1) % 7;
    end
    apply_stimulus();
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] pr, input logic pvs, input logic pde,
                      input int px, input int py);
    st_word[st_len] = pack_pixel(pr, pr ^ 6'h3F, 6'(px), 1'b0, pvs, pde);
    st_r[st_len]    = pr;
    st_de[st_len]   = pde;
    st_x[st_len]    = px;
    st_y[st_len]    = py;
    st_len++;
  endtask

  initial begin
    resetn = 1'b0;
    phase  = 4;
    apply_stimulus();
    repeat (3) @(negedge clk);
    check_output("rst_locked", 32'(locked), 32'd0);
    check_output("rst_bitslip", 32'(bitslip), 32'd0);
    check_output("rst_valid", 32'(valid), 32'd0);
    check_output("rst_align_err", 32'(align_err), 32'd0);
    check_output("rst_x", 32'(x), 32'd0);
    check_output("rst_y", 32'(y), 32'd0);
    resetn = 1'b1;

    // Test 1: four-bit phase offset needs exactly three slips to align
    $display("[TB] test 1: alignment from phase offset 4");
    slips   = 0;
    min_gap = 1000;
    for (int i = 0; i < 500 && !locked; i++) step();
    lock_cycle = cycle;
    check_output("t1_locked", 32'(locked), 32'd1);
    check_output("t1_slips", 32'(slips), 32'd3);
    check_output("t1_gap_ge6", 32'(min_gap >= 6), 32'd1);
    check_output("t1_lock_delay", 32'(lock_cycle - last_slip_cycle), 32'd69);
    check_output("t1_align_err", 32'(align_err), 32'd0);
    check_output("t1_valid_at_lock", 32'(valid), 32'd0);
    step();
    check_output("t1_valid_d1", 32'(valid), 32'd0);
    step();
    check_output("t1_valid_d2", 32'(valid), 32'd1);

    // Test 2: R=2A G=15 B=3F DE=1 -> lane2=4F lane1=6A lane0=6A
    $display("[TB] test 2: pixel unpack");
    lanes_src = {7'h4F, 7'h6A, 7'h6A};
    step();
    step();
    check_output("t2_r_early", 32'(r), 32'd0);
    step();
    check_output("t2_r", 32'(r), 32'h2A);
    check_output("t2_g", 32'(g), 32'h15);
    check_output("t2_b", 32'(b), 32'h3F);
    check_output("t2_de", 32'(de), 32'd1);
    check_output("t2_hs", 32'(hs), 32'd0);
    check_output("t2_vs", 32'(vs), 32'd0);
    check_output("t2_valid", 32'(valid), 32'd1);

    // Test 3: three bad clock words are tolerated, four drop lock
    $display("[TB] test 3: loss of lock");
    lanes_src = '0;
    clk_src   = 7'h00;
    repeat (3) step();
    clk_src = PAT;
    repeat (3) step();
    check_output("t3_survive3", 32'(locked), 32'd1);
    clk_src = 7'h00;
    repeat (4) step();
    check_output("t3_before_drop", 32'(locked), 32'd1);
    step();
    check_output("t3_dropped", 32'(locked), 32'd0);
    check_output("t3_valid_d0", 32'(valid), 32'd1);
    slips   = 0;
    min_gap = 1000;
    step();
    check_output("t3_rehunt_slip", 32'(bitslip), 32'd1);
    check_output("t3_valid_d1", 32'(valid), 32'd1);
    step();
    check_output("t3_valid_d2", 32'(valid), 32'd0);
    check_output("t3_x_cleared", 32'(x), 32'd0);

    // Test 4: stuck clock lane keeps slipping; the error flag sets after the 7th pulse
    $display("[TB] test 4: stuck clock lane");
    for (int i = 0; i < 100 && slips < 7; i++) step();
    check_output("t4_slips7", 32'(slips), 32'd7);
    check_output("t4_err_during_7th", 32'(align_err), 32'd0);
    step();
    check_output("t4_err_after_7th", 32'(align_err), 32'd1);
    repeat (40) step();
    check_output("t4_slips_continue", 32'(slips >= 12), 32'd1);
    check_output("t4_gap_ge6", 32'(min_gap >= 6), 32'd1);
    check_output("t4_err_sticky", 32'(align_err), 32'd1);
    check_output("t4_not_locked", 32'(locked), 32'd0);
    clk_src = PAT;
    for (int i = 0; i < 300 && !locked; i++) step();
    check_output("t4_relocked", 32'(locked), 32'd1);
    check_output("t4_err_cleared", 32'(align_err), 32'd0);
    repeat (2) step();

    // Test 5: VS pulse then three 10-pixel lines, then another VS
    $display("[TB] test 5: x/y tracking");
    repeat (3) push(6'd0, 1'b0, 1'b0, 0, 0);
    repeat (2) push(6'd0, 1'b1, 1'b0, 0, 0);
    repeat (3) push(6'd0, 1'b0, 1'b0, 0, 0);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 10; i++) push(6'(l * 10 + i + 1), 1'b0, 1'b1, i, l);
      repeat (4) push(6'd0, 1'b0, 1'b0, 0, l + 1);
    end
    repeat (2) push(6'd0, 1'b1, 1'b0, 0, 0);
    repeat (3) push(6'd0, 1'b0, 1'b0, 0, 0);
    for (int t = 0; t < st_len + 2; t++) begin
      lanes_src = (t < st_len) ? st_word[t] : '0;
      step();
      if (t >= 2) begin
        check_output($sformatf("t5_x[%0d]", t - 2), 32'(x), 32'(st_x[t-2]));
        check_output($sformatf("t5_y[%0d]", t - 2), 32'(y), 32'(st_y[t-2]));
        check_output($sformatf("t5_de[%0d]", t - 2), 32'(de), 32'(st_de[t-2]));
        if (st_de[t-2]) check_output($sformatf("t5_r[%0d]", t - 2), 32'(r), 32'(st_r[t-2]));
      end
    end

    // Test 6: asynchronous reset in the middle of an active line
    $display("[TB] test 6: reset while locked");
    lanes_src = pack_pixel(6'h11, 6'h22, 6'h33, 1'b0, 1'b0, 1'b1);
    repeat (5) step();
    check_output("t6_pre_de", 32'(de), 32'd1);
    check_output("t6_pre_x", 32'(x), 32'd2);
    #2 resetn = 1'b0;
    #1;
    check_output("t6_locked", 32'(locked), 32'd0);
    check_output("t6_valid", 32'(valid), 32'd0);
    check_output("t6_rgb", 32'({r, g, b}), 32'd0);
    check_output("t6_de", 32'(de), 32'd0);
    check_output("t6_x", 32'(x), 32'd0);
    check_output("t6_y", 32'(y), 32'd0);
    check_output("t6_bitslip", 32'(bitslip), 32'd0);
    phase     = 2;
    lanes_src = '0;
    step();
    resetn  = 1'b1;
    slips   = 0;
    for (int i = 0; i < 300 && !locked; i++) step();
    check_output("t6_relocked", 32'(locked), 32'd1);
    check_output("t6_relock_slips", 32'(slips), 32'd5);
    check_output("t6_align_err", 32'(align_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
